// File: rtl/priority_isr.sv
// Priority resolver and in-service register: picks the highest-priority unmasked request,
// runs the two-pulse INTA handshake, and retires levels on EOI/AEOI with optional rotation.
module priority_isr #(
    parameter int unsigned NUM_IR       = 8,
    parameter int unsigned RESET_LOWEST = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IR-1:0] IRR_priority,
    input  logic [NUM_IR-1:0] IMR,
    input  logic              INTA_pulse,
    input  logic              AEOI,
    input  logic              EOI_valid,
    input  logic              EOI_specific,
    input  logic [2:0]        EOI_level,
    input  logic              rotate_on_eoi,
    output logic              INT,
    output logic [NUM_IR-1:0] INTA_1,
    output logic              INTA_FREEZE,
    output logic [NUM_IR-1:0] ISR,
    output logic              vector_valid,
    output logic [2:0]        vector_level
);

    typedef enum logic [0:0] {StIdle, StAck1} state_e;

    state_e            state_q, state_d;
    logic              int_q, int_d;
    logic [NUM_IR-1:0] inta_1_q, inta_1_d;
    logic              freeze_q, freeze_d;
    logic [NUM_IR-1:0] isr_q, isr_d;
    logic              vv_q, vv_d;
    logic [2:0]        vl_q, vl_d;
    logic [2:0]        lowest_q, lowest_d;
    logic [2:0]        cur_q, cur_d;
    logic              spur_q, spur_d;

    logic [NUM_IR-1:0] eligible;
    logic              elig_found, isr_found;
    logic [2:0]        elig_level, elig_rank, isr_level, isr_rank;
    logic              pending;
    logic              eoi_hit;
    logic [2:0]        eoi_sel;

    assign eligible = IRR_priority & ~IMR;

    // Scan from the lowest-priority rank back to the highest so the last hit is the winner.
    always_comb begin
        elig_found = 1'b0;
        elig_level = 3'd0;
        elig_rank  = 3'd0;
        isr_found  = 1'b0;
        isr_level  = 3'd0;
        isr_rank   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[3'(lowest_q + 3'(i + 1))]) begin
                elig_found = 1'b1;
                elig_level = 3'(lowest_q + 3'(i + 1));
                elig_rank  = 3'(i);
            end
            if (isr_q[3'(lowest_q + 3'(i + 1))]) begin
                isr_found = 1'b1;
                isr_level = 3'(lowest_q + 3'(i + 1));
                isr_rank  = 3'(i);
            end
        end
    end

    assign pending = elig_found && (!isr_found || (elig_rank < isr_rank));

    always_comb begin
        eoi_hit = 1'b0;
        eoi_sel = 3'd0;
        if (EOI_valid) begin
            if (EOI_specific) begin
                eoi_hit = isr_q[EOI_level];
                eoi_sel = EOI_level;
            end else begin
                eoi_hit = isr_found;
                eoi_sel = isr_level;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        int_d    = int_q;
        inta_1_d = '0;
        freeze_d = freeze_q;
        isr_d    = isr_q;
        vv_d     = 1'b0;
        vl_d     = vl_q;
        lowest_d = lowest_q;
        cur_d    = cur_q;
        spur_d   = spur_q;

        // EOI works on the pre-update ISR; any set below is applied afterwards and wins.
        if (eoi_hit) begin
            isr_d[eoi_sel] = 1'b0;
            if (rotate_on_eoi) begin
                lowest_d = eoi_sel;
            end
        end

        unique case (state_q)
            StIdle: begin
                int_d = pending;
                if (INTA_pulse) begin
                    int_d    = 1'b0;
                    freeze_d = 1'b1;
                    state_d  = StAck1;
                    if (pending) begin
                        cur_d               = elig_level;
                        spur_d              = 1'b0;
                        isr_d[elig_level]   = 1'b1;
                        inta_1_d[elig_level] = 1'b1;
                    end else begin
                        cur_d  = 3'd7;
                        spur_d = 1'b1;
                    end
                end
            end
            StAck1: begin
                int_d = 1'b0;
                if (INTA_pulse) begin
                    vv_d     = 1'b1;
                    vl_d     = cur_q;
                    freeze_d = 1'b0;
                    state_d  = StIdle;
                    if (AEOI && !spur_q) begin
                        isr_d[cur_q] = 1'b0;
                        if (rotate_on_eoi) begin
                            lowest_d = cur_q;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            int_q    <= 1'b0;
            inta_1_q <= '0;
            freeze_q <= 1'b0;
            isr_q    <= '0;
            vv_q     <= 1'b0;
            vl_q     <= 3'd0;
            lowest_q <= 3'(RESET_LOWEST);
            cur_q    <= 3'd0;
            spur_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            int_q    <= int_d;
            inta_1_q <= inta_1_d;
            freeze_q <= freeze_d;
            isr_q    <= isr_d;
            vv_q     <= vv_d;
            vl_q     <= vl_d;
            lowest_q <= lowest_d;
            cur_q    <= cur_d;
            spur_q   <= spur_d;
        end
    end

    assign INT          = int_q;
    assign INTA_1       = inta_1_q;
    assign INTA_FREEZE  = freeze_q;
    assign ISR          = isr_q;
    assign vector_valid = vv_q;
    assign vector_level = vl_q;

endmodule

// File: tb/tb_priority_isr.sv
// Directed bench for priority_isr: a rank-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_priority_isr;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] IRR_priority, IMR;
    logic       INTA_pulse, AEOI, EOI_valid, EOI_specific, rotate_on_eoi;
    logic [2:0] EOI_level;
    logic       INT, INTA_FREEZE, vector_valid;
    logic [7:0] INTA_1, ISR;
    logic [2:0] vector_level;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    priority_isr #(.NUM_IR(8), .RESET_LOWEST(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .IRR_priority (IRR_priority),
        .IMR          (IMR),
        .INTA_pulse   (INTA_pulse),
        .AEOI         (AEOI),
        .EOI_valid    (EOI_valid),
        .EOI_specific (EOI_specific),
        .EOI_level    (EOI_level),
        .rotate_on_eoi(rotate_on_eoi),
        .INT          (INT),
        .INTA_1       (INTA_1),
        .INTA_FREEZE  (INTA_FREEZE),
        .ISR          (ISR),
        .vector_valid (vector_valid),
        .vector_level (vector_level)
    );

    always #5 clk = ~clk;

    // Reference model: priority expressed as a rank distance from the lowest level.
    bit       m_ack, m_spur;
    int       m_cur, m_low;
    bit       e_int, e_freeze, e_vv;
    bit [7:0] e_inta1, e_isr;
    bit [2:0] e_vl;

    function automatic int rank(input int lvl, input int low);
        return (lvl - low - 1 + 16) % 8;
    endfunction

    function automatic int best(input bit [7:0] v, input int low);
        int b = -1;
        for (int l = 0; l < 8; l++)
            if (v[l] && (b < 0 || rank(l, low) < rank(b, low))) b = l;
        return b;
    endfunction

    always @(posedge clk) begin : model
        int w, top, tgt, nlow;
        bit pend;
        bit [7:0] nisr;
        if (reset) begin
            m_ack = 0; m_spur = 0; m_cur = 0; m_low = 7;
            e_int = 0; e_freeze = 0; e_vv = 0; e_inta1 = 0; e_isr = 0; e_vl = 0;
        end else begin
            w    = best(IRR_priority & ~IMR, m_low);
            top  = best(e_isr, m_low);
            pend = (w >= 0) && (top < 0 || rank(w, m_low) < rank(top, m_low));
            nisr = e_isr;
            nlow = m_low;
            tgt  = -1;
            if (EOI_valid) tgt = EOI_specific ? (e_isr[EOI_level] ? int'(EOI_level) : -1) : top;
            if (tgt >= 0) begin
                nisr[tgt] = 1'b0;
                if (rotate_on_eoi) nlow = tgt;
            end
            e_inta1 = 0;
            e_vv    = 0;
            if (!m_ack) begin
                e_int = pend;
                if (INTA_pulse) begin
                    e_int = 0; e_freeze = 1; m_ack = 1;
                    if (pend) begin
                        m_cur = w; m_spur = 0; nisr[w] = 1'b1; e_inta1 = 8'b1 << w;
                    end else begin
                        m_cur = 7; m_spur = 1;
                    end
                end
            end else begin
                e_int = 0;
                if (INTA_pulse) begin
                    e_vv = 1; e_vl = 3'(m_cur); e_freeze = 0; m_ack = 0;
                    if (AEOI && !m_spur) begin
                        nisr[m_cur] = 1'b0;
                        if (rotate_on_eoi) nlow = m_cur;
                    end
                end
            end
            e_isr = nisr;
            m_low = nlow;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_INT", 8'(INT), 8'(e_int));
            check("model_INTA_1", INTA_1, e_inta1);
            check("model_FREEZE", 8'(INTA_FREEZE), 8'(e_freeze));
            check("model_ISR", ISR, e_isr);
            check("model_vvalid", 8'(vector_valid), 8'(e_vv));
            check("model_vlevel", 8'(vector_level), 8'(e_vl));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic inta();
        INTA_pulse = 1'b1;
        step();
        INTA_pulse = 1'b0;
    endtask

    task automatic eoi(input bit specific, input bit [2:0] lvl, input bit rot);
        EOI_valid = 1'b1; EOI_specific = specific; EOI_level = lvl; rotate_on_eoi = rot;
        step();
        EOI_valid = 1'b0; EOI_specific = 1'b0; EOI_level = 3'd0; rotate_on_eoi = 1'b0;
    endtask

    initial begin
        reset = 1'b1; IRR_priority = 0; IMR = 0; INTA_pulse = 0; AEOI = 0;
        EOI_valid = 0; EOI_specific = 0; EOI_level = 0; rotate_on_eoi = 0;
        step(); step();
        chk_en = 1'b1;
        reset  = 1'b0;
        step();
        check("reset_ISR", ISR, 8'h00);
        check("reset_INT", 8'(INT), 8'h00);

        // Basic acknowledge of level 3
        IRR_priority = 8'h08; step();
        check("basic_INT", 8'(INT), 8'h01);
        inta();
        check("basic_ISR", ISR, 8'h08);
        check("basic_INTA_1", INTA_1, 8'h08);
        check("basic_FREEZE", 8'(INTA_FREEZE), 8'h01);
        IRR_priority = 8'h00; step();
        check("basic_INTA_1_drop", INTA_1, 8'h00);
        inta();
        check("basic_vvalid", 8'(vector_valid), 8'h01);
        check("basic_vlevel", 8'(vector_level), 8'h03);
        check("basic_FREEZE_off", 8'(INTA_FREEZE), 8'h00);
        eoi(1'b0, 3'd0, 1'b0);
        check("basic_eoi_ISR", ISR, 8'h00);

        // Mask and nesting
        IRR_priority = 8'h24; IMR = 8'h04; step();
        inta();
        check("mask_ISR", ISR, 8'h20);
        IRR_priority = 8'h04; inta();
        check("mask_vlevel", 8'(vector_level), 8'h05);
        IRR_priority = 8'h02; step();
        check("nest_INT", 8'(INT), 8'h01);
        inta();
        check("nest_ISR", ISR, 8'h22);
        IRR_priority = 8'h00; inta();
        check("nest_vlevel", 8'(vector_level), 8'h01);
        eoi(1'b0, 3'd0, 1'b0);
        check("nest_eoi_ISR", ISR, 8'h20);
        IMR = 8'h00; IRR_priority = 8'h80; step(); step();
        check("lower_no_INT", 8'(INT), 8'h00);
        IRR_priority = 8'h00; eoi(1'b0, 3'd0, 1'b0);
        step();

        // Rotation
        IRR_priority = 8'h11; step();
        inta();
        check("rot_first_INTA_1", INTA_1, 8'h01);
        IRR_priority = 8'h10; inta();
        eoi(1'b0, 3'd0, 1'b1);
        IRR_priority = 8'h11; step();
        inta();
        check("rot_second_INTA_1", INTA_1, 8'h10);
        IRR_priority = 8'h01; inta();
        check("rot_vlevel", 8'(vector_level), 8'h04);
        IRR_priority = 8'h00; eoi(1'b0, 3'd0, 1'b0);
        step();

        // AEOI and specific EOI
        AEOI = 1'b1; IRR_priority = 8'h40; step();
        inta();
        IRR_priority = 8'h00; inta();
        check("aeoi_ISR", ISR, 8'h00);
        check("aeoi_vlevel", 8'(vector_level), 8'h06);
        AEOI = 1'b0; IRR_priority = 8'h04; step();
        inta();
        IRR_priority = 8'h00; inta();
        check("spec_pre_ISR", ISR, 8'h04);
        eoi(1'b0 ^ 1'b1, 3'd5, 1'b0);
        check("spec_miss_ISR", ISR, 8'h04);
        eoi(1'b1, 3'd2, 1'b0);
        check("spec_ISR", ISR, 8'h00);

        // EOI on the same bit as the first-INTA set: the set wins
        IRR_priority = 8'h08; step();
        EOI_valid = 1'b1; EOI_specific = 1'b1; EOI_level = 3'd3;
        inta();
        EOI_valid = 1'b0; EOI_specific = 1'b0; EOI_level = 3'd0;
        check("set_wins_ISR", ISR, 8'h08);
        IRR_priority = 8'h00; inta();
        eoi(1'b0, 3'd0, 1'b0);

        // Spurious: request vanishes as INTA#1 arrives
        IRR_priority = 8'h02; step();
        check("spur_INT", 8'(INT), 8'h01);
        IRR_priority = 8'h00; inta();
        check("spur_INTA_1", INTA_1, 8'h00);
        check("spur_ISR", ISR, 8'h00);
        inta();
        check("spur_vlevel", 8'(vector_level), 8'h07);

        // Reset in the middle of a sequence
        IRR_priority = 8'h01; step();
        inta();
        check("rst_pre_ISR", ISR, 8'h01);
        IRR_priority = 8'h00; reset = 1'b1; step();
        reset = 1'b0;
        check("rst_ISR", ISR, 8'h00);
        check("rst_FREEZE", 8'(INTA_FREEZE), 8'h00);
        check("rst_vlevel", 8'(vector_level), 8'h00);
        inta();
        check("rst_spur_INTA_1", INTA_1, 8'h00);
        check("rst_spur_FREEZE", 8'(INTA_FREEZE), 8'h01);
        inta();
        check("rst_spur_vlevel", 8'(vector_level), 8'h07);
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
